// File: rtl/cargador_ds.sv
// Serial-to-parallel loader feeding the 16-bit DS register: assembles an
// MSB-first strobed word, checks its parity, and issues a single load pulse on a good frame.
module cargador_ds #(
    parameter int DATA_W     = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              SBIT,
    input  logic              SSTB,
    input  logic              ABORT,
    output logic [DATA_W-1:0] DS_D,
    output logic              DS_ENA,
    output logic              BUSY,
    output logic              ERR,
    output logic [7:0]        FRAMES
);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

    localparam logic       PAR_SENSE = (PARITY_ODD != 0);
    localparam logic [4:0] LAST_BIT  = 5'(DATA_W - 1);

    state_t            state;
    logic [DATA_W-1:0] sr;
    logic [4:0]        cnt;
    logic              par_ok;

    assign par_ok = (((^sr) ^ SBIT) == PAR_SENSE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            sr     <= '0;
            cnt    <= '0;
            DS_D   <= '0;
            DS_ENA <= 1'b0;
            BUSY   <= 1'b0;
            ERR    <= 1'b0;
            FRAMES <= '0;
        end else begin
            DS_ENA <= 1'b0;
            case (state)
                IDLE: begin
                    // ABORT is meaningless here, so START wins even if both are high
                    if (START) begin
                        state <= SHIFT;
                        sr    <= '0;
                        cnt   <= '0;
                        ERR   <= 1'b0;
                        BUSY  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (ABORT) begin
                        state <= IDLE;
                        sr    <= '0;
                        cnt   <= '0;
                        BUSY  <= 1'b0;
                    end else if (SSTB) begin
                        sr  <= {sr[DATA_W-2:0], SBIT};
                        cnt <= cnt + 5'd1;
                        if (cnt == LAST_BIT)
                            state <= PARITY;
                    end
                end
                PARITY: begin
                    if (ABORT) begin
                        state <= IDLE;
                        sr    <= '0;
                        cnt   <= '0;
                        BUSY  <= 1'b0;
                    end else if (SSTB) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                        if (par_ok) begin
                            DS_D   <= sr;
                            DS_ENA <= 1'b1;
                            FRAMES <= FRAMES + 8'd1;
                        end else begin
                            ERR <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
